// File: rtl/event_stream_framer.sv
// Event byte framer: wraps each event as header, packed 32-bit data words and a trailer on AXI4-Stream.
// Latency: a word written to the output FIFO appears on m_axis_tdata one cycle later.
// Backpressure: m_axis_tready stalls the FIFO only; when it is full, words are dropped and overflow_o is flagged.

// Generic first-word-fall-through FIFO.
// Latency: a written word is visible on rd_dat the cycle after the write.
// Backpressure: a write into a full FIFO is dropped (wr_drop) unless a pop happens in the same cycle.
module event_stream_framer_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_drop,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          full;
    logic          push;
    logic          pop;

    assign full    = (cnt == FULL_CNT);
    assign rd_vld  = (cnt != '0);
    assign pop     = rd_vld && rd_rdy;
    assign push    = wr_vld && (!full || pop);
    assign wr_drop = wr_vld && full && !pop;
    // Gate the read port so an empty FIFO presents zeros rather than stale storage.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge core_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Event framer top: phase strobe, byte packer, framing FSM and output FIFO.
// Latency: header written in the first-byte cycle, trailer two cycles after the last byte.
// Backpressure: none toward the event buffer; a full FIFO drops words and sets overflow_o.
module event_stream_framer #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] HDR_MAGIC  = 16'hEB0C
) (
    input  logic        ifclk_i,
    input  logic        ifclk_rstn_i,
    output logic        dout_data_phase_o,
    input  logic [7:0]  dat_i,
    input  logic        dat_valid_i,
    input  logic        dat_last_i,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        overflow_o,
    input  logic        err_clr_i,
    output logic [15:0] event_cnt_o
);
    typedef enum logic [1:0] {IDLE, DATA, PAD, TRL} state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] dat;
    } word_t;

    state_t      state;
    state_t      state_nxt;
    logic        phase;
    logic        accept;
    logic        word_done;
    logic        wr_vld;
    logic        wr_drop;
    word_t       wr_word;
    word_t       rd_word;
    logic [31:0] pk;
    logic [31:0] lane_word;
    logic [1:0]  ptr;
    logic [15:0] byte_cnt;
    logic [15:0] evt_cnt;
    logic [7:0]  xsum;
    logic        ovf;

    assign accept    = dat_valid_i && phase && ((state == IDLE) || (state == DATA));
    assign word_done = (ptr == 2'd3) || dat_last_i;

    always_comb begin
        lane_word = pk;
        lane_word[8*ptr +: 8] = dat_i;
    end

    always_ff @(posedge ifclk_i or negedge ifclk_rstn_i) begin
        if (!ifclk_rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = dat_last_i ? PAD : DATA;
            DATA:    if (accept && dat_last_i) state_nxt = PAD;
            PAD:     state_nxt = TRL;
            TRL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A single-byte event writes its header in the byte cycle, so its data word goes out from PAD.
    always_comb begin
        wr_vld  = 1'b0;
        wr_word = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    wr_vld  = 1'b1;
                    wr_word = '{last: 1'b0, dat: {HDR_MAGIC, evt_cnt}};
                end
            end
            DATA: begin
                if (accept && word_done) begin
                    wr_vld  = 1'b1;
                    wr_word = '{last: 1'b0, dat: lane_word};
                end
            end
            PAD: begin
                if (ptr != 2'd0) begin
                    wr_vld  = 1'b1;
                    wr_word = '{last: 1'b0, dat: pk};
                end
            end
            TRL: begin
                wr_vld  = 1'b1;
                wr_word = '{last: 1'b1, dat: {byte_cnt, 8'hA5, xsum}};
            end
            default: begin
                wr_vld  = 1'b0;
                wr_word = '0;
            end
        endcase
    end

    always_ff @(posedge ifclk_i or negedge ifclk_rstn_i) begin
        if (!ifclk_rstn_i) begin
            pk       <= '0;
            ptr      <= '0;
            byte_cnt <= '0;
            xsum     <= '0;
            evt_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pk       <= {24'd0, dat_i};
                        ptr      <= 2'd1;
                        byte_cnt <= 16'd1;
                        xsum     <= dat_i;
                    end
                end
                DATA: begin
                    if (accept) begin
                        xsum <= xsum ^ dat_i;
                        if (byte_cnt != 16'hFFFF) begin
                            byte_cnt <= byte_cnt + 16'd1;
                        end
                        if (word_done) begin
                            pk  <= '0;
                            ptr <= 2'd0;
                        end else begin
                            pk  <= lane_word;
                            ptr <= ptr + 2'd1;
                        end
                    end
                end
                PAD: begin
                    pk  <= '0;
                    ptr <= 2'd0;
                end
                TRL: begin
                    evt_cnt <= evt_cnt + 16'd1;
                end
                default: begin
                    pk <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge ifclk_i or negedge ifclk_rstn_i) begin
        if (!ifclk_rstn_i) begin
            phase <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            phase <= ~phase;
            // A drop in the same cycle as a clear must win so no overflow goes unreported.
            if (wr_drop) begin
                ovf <= 1'b1;
            end else if (err_clr_i) begin
                ovf <= 1'b0;
            end
        end
    end

    event_stream_framer_fifo #(
        .W     ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (ifclk_i),
        .arst_n   (ifclk_rstn_i),
        .wr_vld   (wr_vld),
        .wr_dat   (wr_word),
        .wr_drop  (wr_drop),
        .rd_vld   (m_axis_tvalid),
        .rd_rdy   (m_axis_tready),
        .rd_dat   (rd_word)
    );

    assign m_axis_tdata      = rd_word.dat;
    assign m_axis_tlast      = rd_word.last;
    assign dout_data_phase_o = phase;
    assign overflow_o        = ovf;
    assign event_cnt_o       = evt_cnt;
endmodule

// File: tb/tb_event_stream_framer.sv
// Directed bench for event_stream_framer: hand-computed frames, overflow, mid-event reset, noisy random run.
module tb_event_stream_framer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phase;
    logic [7:0]  dat = '0;
    logic        dat_valid = 1'b0;
    logic        dat_last = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        overflow;
    logic        err_clr = 1'b0;
    logic [15:0] event_cnt;

    logic        rdy_set = 1'b1;
    logic        rnd_mode = 1'b0;
    logic        rnd_rdy = 1'b1;

    int          n_chk = 0;
    int          n_err = 0;
    logic [32:0] rx_q[$];
    logic [32:0] exp_q[$];

    assign tready = rnd_mode ? rnd_rdy : rdy_set;

    always #5 clk = ~clk;

    event_stream_framer dut (
        .ifclk_i           (clk),
        .ifclk_rstn_i      (rst_n),
        .dout_data_phase_o (phase),
        .dat_i             (dat),
        .dat_valid_i       (dat_valid),
        .dat_last_i        (dat_last),
        .m_axis_tdata      (tdata),
        .m_axis_tvalid     (tvalid),
        .m_axis_tready     (tready),
        .m_axis_tlast      (tlast),
        .overflow_o        (overflow),
        .err_clr_i         (err_clr),
        .event_cnt_o       (event_cnt)
    );

    always @(negedge clk) begin
        if (tvalid && tready) rx_q.push_back({tlast, tdata});
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dat_valid = 1'b0;
        dat_last = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
    endtask

    // Drives one byte in the next high-phase cycle; optional garbage in the preceding low-phase cycle.
    task automatic send_byte(input logic [7:0] b, input logic last, input bit noise, input logic clr);
        int guard = 0;
        while (phase !== 1'b0 && guard < 4) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (noise) begin
            dat_valid = 1'b1;
            dat = 8'($urandom);
            dat_last = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        dat_valid = 1'b1;
        dat = b;
        dat_last = last;
        err_clr = clr;
        @(posedge clk);
        #1;
        dat_valid = 1'b0;
        dat_last = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic send_event(input logic [7:0] bytes[$], input bit noise);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], (i == bytes.size() - 1), noise, 1'b0);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (tvalid && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_timeout", 64'(g < 400), 64'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic model_event(input logic [7:0] bytes[$], input logic [15:0] evn);
        logic [31:0] w;
        logic [7:0]  x;
        int          n;
        n = bytes.size();
        w = '0;
        x = '0;
        exp_q.push_back({1'b0, 16'hEB0C, evn});
        for (int i = 0; i < n; i++) begin
            w[8*(i%4) +: 8] = bytes[i];
            x ^= bytes[i];
            if ((i % 4 == 3) || (i == n - 1)) begin
                exp_q.push_back({1'b0, w});
                w = '0;
            end
        end
        exp_q.push_back({1'b1, 16'(n), 8'hA5, x});
    endtask

    initial begin
        logic [7:0] ev[$];

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_event_cnt", 64'(event_cnt), 64'd0);
        chk("rst_phase", 64'(phase), 64'd0);

        // Eight bytes: two full data words, no partial word
        do_reset();
        ev = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_event(ev, 1'b0);
        drain();
        exp_q = '{33'h0_EB0C0000, 33'h0_04030201, 33'h0_08070605, 33'h1_0008A508};
        check_stream("ev8");
        chk("ev8_cnt", 64'(event_cnt), 64'd1);

        // Five bytes: one full word plus a one-lane partial word
        do_reset();
        ev = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_event(ev, 1'b0);
        drain();
        exp_q = '{33'h0_EB0C0000, 33'h0_44332211, 33'h0_00000055, 33'h1_0005A511};
        check_stream("ev5");

        // Single byte event
        do_reset();
        ev = '{8'h7F};
        send_event(ev, 1'b0);
        drain();
        exp_q = '{33'h0_EB0C0000, 33'h0_0000007F, 33'h1_0001A57F};
        check_stream("ev1");

        // Overflow with tready low: header visible one cycle after write, then 80 bytes overrun 16 slots
        do_reset();
        rdy_set = 1'b0;
        send_byte(8'd1, 1'b0, 1'b0, 1'b0);
        chk("lat_tvalid", 64'(tvalid), 64'd1);
        chk("lat_tdata", 64'(tdata), 64'hEB0C0000);
        for (int i = 2; i <= 80; i++) send_byte(8'(i), (i == 80), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_evcnt", 64'(event_cnt), 64'd1);
        pulse_clr();
        chk("ovf_clr", 64'(overflow), 64'd0);
        send_byte(8'h5A, 1'b1, 1'b0, 1'b1);
        chk("ovf_clr_vs_drop", 64'(overflow), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        pulse_clr();
        chk("ovf_clr2", 64'(overflow), 64'd0);
        chk("ovf_evcnt2", 64'(event_cnt), 64'd2);
        rdy_set = 1'b1;
        drain();
        chk("ovf_depth", 64'(rx_q.size()), 64'd16);
        if (rx_q.size() == 16) begin
            chk("ovf_w0", 64'(rx_q[0]), 64'h0_EB0C0000);
            chk("ovf_w1", 64'(rx_q[1]), 64'h0_04030201);
            chk("ovf_w15", 64'(rx_q[15]), 64'h0_3C3B3A39);
        end
        rx_q.delete();
        ev = '{8'hAA, 8'hBB};
        send_event(ev, 1'b0);
        drain();
        exp_q = '{33'h0_EB0C0002, 33'h0_0000BBAA, 33'h1_0002A511};
        check_stream("post_ovf");

        // Reset in the middle of an event
        do_reset();
        send_byte(8'hC1, 1'b0, 1'b0, 1'b0);
        send_byte(8'hC2, 1'b0, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
        chk("mid_rst_tdata", 64'(tdata), 64'd0);
        chk("mid_rst_evcnt", 64'(event_cnt), 64'd0);
        chk("mid_rst_phase", 64'(phase), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete();
        ev = '{8'h99};
        send_event(ev, 1'b0);
        drain();
        exp_q = '{33'h0_EB0C0000, 33'h0_00000099, 33'h1_0001A599};
        check_stream("after_rst");

        // 100 events with low-phase noise and random tready
        do_reset();
        rnd_mode = 1'b1;
        for (int e = 0; e < 100; e++) begin
            int len;
            len = $urandom_range(1, 12);
            ev.delete();
            for (int k = 0; k < len; k++) ev.push_back(8'($urandom));
            model_event(ev, 16'(e));
            send_event(ev, 1'b1);
        end
        rnd_mode = 1'b0;
        drain();
        check_stream("rand");
        chk("rand_evcnt", 64'(event_cnt), 64'd100);
        chk("rand_ovf", 64'(overflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
